// File: rtl/cmp_tracker.sv
// Compare tracker: registered a-vs-b compare plus running max/min of a and a saturating sample count.
// Optional running max/min registers are built only when CMP_TRACKER_MINMAX_EN is defined.
module cmp_tracker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             clear,
  output logic             out_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, TRACK, SAT} state_t;

  state_t state;
  logic   prev_signed;
  logic   first_c;

  function automatic logic less_than(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic             sgn);
    if (sgn) return $signed(x) < $signed(y);
    else     return x < y;
  endfunction

  // Sample starts a fresh run: after restart, in IDLE, or on a compare-mode change.
  assign first_c = clear || (state == IDLE) || (is_signed != prev_signed);

  // Control FSM, compare result and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prev_signed <= 1'b0;
      out_valid   <= 1'b0;
      gt          <= 1'b0;
      eq          <= 1'b0;
      lt          <= 1'b0;
      count       <= '0;
      sat         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gt          <= less_than(b, a, is_signed);
        eq          <= (a == b);
        lt          <= less_than(a, b, is_signed);
        prev_signed <= is_signed;
        if (first_c) begin
          count <= CNT_ONE;
          sat   <= (CNT_MAX == CNT_ONE);
          state <= (CNT_MAX == CNT_ONE) ? SAT : TRACK;
        end else if (state == TRACK) begin
          count <= count + CNT_ONE;
          if (count + CNT_ONE == CNT_MAX) begin
            sat   <= 1'b1;
            state <= SAT;
          end
        end
      end else if (clear) begin
        count <= '0;
        sat   <= 1'b0;
        state <= IDLE;
      end
    end
  end

`ifdef CMP_TRACKER_MINMAX_EN
  // Running extremes of a, compared in the mode of the current sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_val <= '0;
      min_val <= '0;
    end else if (in_valid) begin
      if (first_c) begin
        max_val <= a;
        min_val <= a;
      end else begin
        if (less_than(max_val, a, is_signed)) max_val <= a;
        if (less_than(a, min_val, is_signed)) min_val <= a;
      end
    end else if (clear) begin
      max_val <= '0;
      min_val <= '0;
    end
  end
`else
  assign max_val = '0;
  assign min_val = '0;
`endif

endmodule

// File: tb/tb_cmp_tracker.sv
// Randomized self-checking bench for cmp_tracker against a behavioural model.
// Two instances: default counter width and CNT_W=2 for saturation corners.
module tb_cmp_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, is_signed, clear;
  logic [3:0] a, b;

  logic       ov1, gt1, eq1, lt1, sat1;
  logic [3:0] mx1, mn1;
  logic [7:0] cnt1;
  logic       ov2, gt2, eq2, lt2, sat2;
  logic [3:0] mx2, mn2;
  logic [1:0] cnt2;

  cmp_tracker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .is_signed(is_signed), .clear(clear), .out_valid(ov1), .gt(gt1),
    .eq(eq1), .lt(lt1), .max_val(mx1), .min_val(mn1), .count(cnt1), .sat(sat1));

  cmp_tracker #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .is_signed(is_signed), .clear(clear), .out_valid(ov2), .gt(gt2),
    .eq(eq2), .lt(lt2), .max_val(mx2), .min_val(mn2), .count(cnt2), .sat(sat2));

  typedef struct {
    bit       have;
    bit       prev;
    bit       ov, gt, eq, lt;
    bit [3:0] mx, mn;
    int       cnt;
  } model_t;

  model_t m1, m2;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ival(input bit [3:0] x, input bit sg);
    return sg ? int'($signed(x)) : int'(x);
  endfunction

  function automatic model_t model_step(input model_t s, input int cmax, input bit rst,
                                        input bit iv, input bit sg, input bit [3:0] av,
                                        input bit [3:0] bv, input bit clr);
    model_t n = s;
    if (rst) begin
      n = '{have: 0, prev: 0, ov: 0, gt: 0, eq: 0, lt: 0, mx: 0, mn: 0, cnt: 0};
      return n;
    end
    n.ov = iv;
    if (clr) begin
      n.have = 0;
      if (!iv) begin n.cnt = 0; n.mx = 0; n.mn = 0; end
    end
    if (iv) begin
      n.gt = ival(av, sg) > ival(bv, sg);
      n.eq = av == bv;
      n.lt = ival(av, sg) < ival(bv, sg);
      if (!n.have || sg != n.prev) begin
        n.cnt = 1; n.mx = av; n.mn = av;
      end else begin
        n.cnt = (n.cnt < cmax) ? n.cnt + 1 : cmax;
        if (ival(av, sg) > ival(n.mx, sg)) n.mx = av;
        if (ival(av, sg) < ival(n.mn, sg)) n.mn = av;
      end
      n.have = 1;
      n.prev = sg;
    end
    return n;
  endfunction

  task automatic check_dut(input string p, input model_t m, input int cmax, input logic ov,
                           input logic g, input logic e, input logic l, input logic [3:0] mx,
                           input logic [3:0] mn, input logic [31:0] cnt, input logic st);
    logic [3:0] emx, emn;
`ifdef CMP_TRACKER_MINMAX_EN
    emx = m.mx; emn = m.mn;
`else
    emx = '0; emn = '0;
`endif
    check({p, "_out_valid"}, 32'(ov), 32'(m.ov));
    check({p, "_gt"}, 32'(g), 32'(m.gt));
    check({p, "_eq"}, 32'(e), 32'(m.eq));
    check({p, "_lt"}, 32'(l), 32'(m.lt));
    check({p, "_max_val"}, 32'(mx), 32'(emx));
    check({p, "_min_val"}, 32'(mn), 32'(emn));
    check({p, "_count"}, cnt, 32'(m.cnt));
    check({p, "_sat"}, 32'(st), 32'(m.cnt == cmax));
  endtask

  task automatic step(input bit iv, input bit sg, input bit [3:0] av, input bit [3:0] bv,
                      input bit clr, input bit rst);
    in_valid = iv; is_signed = sg; a = av; b = bv; clear = clr; reset = rst;
    @(posedge clk);
    m1 = model_step(m1, 255, rst, iv, sg, av, bv, clr);
    m2 = model_step(m2, 3, rst, iv, sg, av, bv, clr);
    #1;
    check_dut("d1", m1, 255, ov1, gt1, eq1, lt1, mx1, mn1, 32'(cnt1), sat1);
    check_dut("d2", m2, 3, ov2, gt2, eq2, lt2, mx2, mn2, 32'(cnt2), sat2);
  endtask

  bit [3:0] stream [4] = '{4'h3, 4'hE, 4'h7, 4'h8};
  bit       sg_r;

  initial begin
    in_valid = 0; is_signed = 0; a = 0; b = 0; clear = 0; reset = 1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("reset_count", 32'(cnt1), 32'd0);

    // Basic signed compare and mode restart.
    step(1, 1, 4'h4, 4'h1, 0, 0);
    check("ex1_gt", 32'(gt1), 32'd1);
    check("ex1_count", 32'(cnt1), 32'd1);
    step(0, 1, 4'h0, 4'h0, 0, 0);
    check("idle_hold_count", 32'(cnt1), 32'd1);
    step(1, 1, 4'h4, 4'hF, 0, 0);
    check("ex2_signed_gt", 32'(gt1), 32'd1);
    step(1, 0, 4'h4, 4'hF, 0, 0);
    check("ex2_unsigned_lt", 32'(lt1), 32'd1);
    check("ex2_mode_restart", 32'(cnt1), 32'd1);

    // Signed then unsigned stream for max/min.
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, stream[i], 4'h0, 0, 0);
    check("stream_s_count", 32'(cnt1), 32'd4);
`ifdef CMP_TRACKER_MINMAX_EN
    check("stream_s_max", 32'(mx1), 32'h7);
    check("stream_s_min", 32'(mn1), 32'h8);
`endif
    for (int i = 0; i < 4; i++) step(1, 0, stream[i], 4'h0, 0, 0);
`ifdef CMP_TRACKER_MINMAX_EN
    check("stream_u_max", 32'(mx1), 32'hE);
    check("stream_u_min", 32'(mn1), 32'h3);
`endif
    check("stream_d2_sat", 32'(sat2), 32'd1);
    check("stream_d2_count", 32'(cnt2), 32'd3);

    // clear with and without a sample.
    step(1, 0, 4'h5, 4'h9, 1, 0);
    check("clr_iv_count", 32'(cnt1), 32'd1);
    check("clr_iv_valid", 32'(ov1), 32'd1);
    step(0, 0, 4'h0, 4'h0, 1, 0);
    check("clr_count", 32'(cnt1), 32'd0);
    check("clr_lt_hold", 32'(lt1), 32'd1);

    // Reset with a sample in flight.
    step(1, 0, 4'h6, 4'h2, 0, 0);
    step(1, 0, 4'h6, 4'h2, 0, 1);
    check("rst_iv_valid", 32'(ov1), 32'd0);
    step(1, 0, 4'h2, 4'h2, 0, 0);
    check("post_rst_count", 32'(cnt1), 32'd1);

    // Long single-mode run to saturate the 8-bit counter.
    for (int i = 0; i < 300; i++) step(1, 1, 4'($urandom), 4'($urandom), 0, 0);
    check("long_sat", 32'(sat1), 32'd1);
    check("long_count", 32'(cnt1), 32'd255);

    // Random traffic with occasional clear, reset and mode flips.
    sg_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 50 == 0) sg_r = ~sg_r;
      step(($urandom % 4) != 0, sg_r, 4'($urandom), 4'($urandom),
           ($urandom % 40) == 0, ($urandom % 150) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
